// File: rtl/pulse_scheduler.sv
// Pseudo-random pulse scheduler: LFSR-drawn gap, width and channel per pulse.
// Optional build macro PULSE_SCHED_MASK_EN adds a per-channel output mask ch_mask.
module pulse_scheduler #(
  parameter int unsigned UNIT       = 20,
  parameter int unsigned NUM_PULSES = 100,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
`ifdef PULSE_SCHED_MASK_EN
  input  logic [9:0] ch_mask,
`endif
  output logic [9:0] dout,
  output logic       busy,
  output logic       done,
  output logic [7:0] pulse_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_GAP,
    ST_PULSE,
    ST_DONE
  } state_e;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [10:0] UNIT_W   = 11'(UNIT);
  localparam logic [7:0]  NUM_W    = 8'(NUM_PULSES);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [10:0] timer_q, timer_d;
  logic [1:0]  wid_q, wid_d;
  logic [3:0]  chan_q, chan_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [9:0]  dout_q, dout_d;

  logic [15:0] lfsr_adv;
  logic [2:0]  gap_draw;
  logic [1:0]  wid_draw;
  logic [3:0]  chan_draw;
  logic [7:0]  cnt_inc;
  logic        ch_en;

  assign lfsr_adv  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign gap_draw  = 3'(lfsr_adv[4:0] % 5'd6);
  assign wid_draw  = 2'(2'd1 + 2'(lfsr_adv[9:5] % 5'd3));
  assign chan_draw = 4'(lfsr_adv[15:10] % 6'd10);
  assign cnt_inc   = cnt_q + 8'd1;

`ifdef PULSE_SCHED_MASK_EN
  assign ch_en = ch_mask[chan_d];
`else
  assign ch_en = 1'b1;
`endif

  // NOTE: every _d signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    timer_d = timer_q;
    wid_d   = wid_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_DRAW;
            cnt_d   = '0;
          end
        end
        ST_DRAW: begin
          lfsr_d = lfsr_adv;
          wid_d  = wid_draw;
          chan_d = chan_draw;
          if (gap_draw != 3'd0) begin
            state_d = ST_GAP;
            timer_d = 11'(gap_draw) * UNIT_W - 11'd1;
          end else begin
            state_d = ST_PULSE;
            timer_d = 11'(wid_draw) * UNIT_W - 11'd1;
          end
        end
        ST_GAP: begin
          if (timer_q == '0) begin
            state_d = ST_PULSE;
            timer_d = 11'(wid_q) * UNIT_W - 11'd1;
          end else begin
            timer_d = timer_q - 11'd1;
          end
        end
        ST_PULSE: begin
          if (timer_q == '0) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == NUM_W) ? ST_DONE : ST_DRAW;
          end else begin
            timer_d = timer_q - 11'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // dout is registered, so it is decoded from the state being entered.
    dout_d = ((state_d == ST_PULSE) && ch_en) ? (10'd1 << chan_d) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED_EFF;
      timer_q <= '0;
      wid_q   <= '0;
      chan_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      timer_q <= timer_d;
      wid_q   <= wid_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler (UNIT=2, NUM_PULSES=3, SEED=1): expected per-cycle trace queued, monitor compares.
module tb_pulse_scheduler;

  localparam int UNIT = 2;
  localparam int NP   = 3;
`ifdef PULSE_SCHED_MASK_EN
  localparam bit MASK_BUILD = 1'b1;
`else
  localparam bit MASK_BUILD = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       abort   = 1'b0;
  logic [9:0] ch_mask = 10'h3FF;
  logic [9:0] dout;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;

  always #5 clk = ~clk;

  pulse_scheduler #(
    .UNIT       (UNIT),
    .NUM_PULSES (NP),
    .SEED       (16'h0001)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
`ifdef PULSE_SCHED_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  typedef struct packed {
    logic [9:0] dout;
    logic       done;
    logic [7:0] cnt;
  } rec_t;

  rec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rec_idx  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Seed 1 draws: pulse 0x020 x2, 0x004 x4, 0x002 x6, each preceded by one DRAW cycle, then DONE.
  task automatic push_trace(input int upto, input logic [9:0] m);
    logic [9:0] vals[3];
    int         lens[3];
    int         n;
    vals = '{10'h020, 10'h004, 10'h002};
    lens = '{2, 4, 6};
    n = 0;
    for (int p = 0; p < 3; p++) begin
      if (n < upto) exp_q.push_back('{dout: 10'h000, done: 1'b0, cnt: 8'(p)});
      n++;
      for (int k = 0; k < lens[p]; k++) begin
        if (n < upto) exp_q.push_back('{dout: vals[p] & m, done: 1'b0, cnt: 8'(p)});
        n++;
      end
    end
    if (n < upto) exp_q.push_back('{dout: 10'h000, done: 1'b1, cnt: 8'd3});
  endtask

  function automatic logic [9:0] eff_mask();
    return MASK_BUILD ? ch_mask : 10'h3FF;
  endfunction

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Monitor: every busy cycle must match the next queued record.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (rst_n && (busy || done)) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_busy_cycle", 32'(busy), 32'd0);
        end else begin
          r = exp_q.pop_front();
          check($sformatf("trace[%0d]", rec_idx), 32'({dout, done, pulse_cnt}), 32'(r));
          rec_idx++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(pulse_cnt), 32'd0);
    do_reset();

    // Full run with start held throughout; released during DONE.
    push_trace(16, eff_mask());
    start = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    check("held_done_strobe", 32'(done), 32'd1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_idle_done", 32'(done), 32'd0);
    check("held_final_cnt", 32'(pulse_cnt), 32'd3);
    drain("held_drain");

    // Asynchronous reset in the middle of the first pulse.
    do_reset();
    push_trace(2, eff_mask());
    pulse_start();
    @(posedge clk);
    #1;
    check("midrst_pulse_on", 32'(dout), 32'(10'h020 & eff_mask()));
    #6 rst_n = 1'b0;
    #1;
    check("midrst_dout_async", 32'(dout), 32'd0);
    check("midrst_busy_async", 32'(busy), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drain("midrst_drain");
    check("midrst_cnt", 32'(pulse_cnt), 32'd0);
    push_trace(16, eff_mask());
    pulse_start();
    drain("after_rst_run_drain");
    check("after_rst_run_cnt", 32'(pulse_cnt), 32'd3);

    // start and abort together in IDLE: start wins, run completes.
    do_reset();
    push_trace(16, eff_mask());
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    drain("start_wins_drain");
    check("start_wins_cnt", 32'(pulse_cnt), 32'd3);

    // Abort during the second pulse.
    do_reset();
    push_trace(6, eff_mask());
    pulse_start();
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_cnt", 32'(pulse_cnt), 32'd1);
    repeat (3) @(posedge clk);
    drain("abort_drain");

    // Channel mask clearing channel 5 (only effective in the mask build).
    do_reset();
    ch_mask = 10'h3DF;
    push_trace(16, eff_mask());
    pulse_start();
    drain("mask_drain");
    check("mask_cnt", 32'(pulse_cnt), 32'd3);
    ch_mask = 10'h3FF;

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
